// File: rtl/eth_tx_framer_pkg.sv
// Ethernet TX framer shared definitions.
// Header/CRC constants and FSM state encoding.
package eth_tx_framer_pkg;

   localparam int          ETH_HDR_LEN = 14;
   localparam logic [15:0] ETHERTYPE   = 16'h0800;
   localparam int          MIN_FRAME   = 60;
   localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
   localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
   localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_HDR  = 3'd1,
      ST_BODY = 3'd2,
      ST_PAD  = 3'd3,
      ST_FCS  = 3'd4,
      ST_GAP  = 3'd5
   } state_t;

endpackage

// File: rtl/eth_tx_framer_if.sv
// Packet-in / byte-out handshake bundle of the TX framer.
// master = network stack + MAC side, slave = framer.
interface eth_tx_framer_if #(
   parameter int PKT_LEN = 140
);

   logic [PKT_LEN*8-1:0] in_data;
   logic                 in_valid;
   logic                 in_ready;
   logic [7:0]           out_data;
   logic                 out_valid;
   logic                 out_last;
   logic                 out_ready;

   modport master (
      output in_data, in_valid, out_ready,
      input  in_ready, out_data, out_valid, out_last
   );

   modport slave (
      input  in_data, in_valid, out_ready,
      output in_ready, out_data, out_valid, out_last
   );

endinterface

// File: rtl/eth_crc32.sv
// Byte-wide Ethernet CRC-32 (reflected) accumulator.
// clr reloads the init value; en folds in one byte.
module eth_crc32
   import eth_tx_framer_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clr,
   input  logic        en,
   input  logic [7:0]  din,
   output logic [31:0] crc
);

   function automatic logic [31:0] crc_next(
      input logic [31:0] c,
      input logic [7:0]  d
   );
      logic [31:0] r;
      r = c ^ {24'h0, d};
      for (int i = 0; i < 8; i++) begin
         r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
      end
      return r;
   endfunction

   // CRC register: reload on reset/clear, update per byte
   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         crc <= CRC_INIT;
      end else if (en) begin
         crc <= crc_next(crc, din);
      end
   end

endmodule

// File: rtl/eth_tx_framer.sv
// Ethernet II TX framer: header, IP packet, pad, FCS, IFG.
// Outputs decode from registered state so they hold under stall.
module eth_tx_framer
   import eth_tx_framer_pkg::*;
#(
   parameter int          PAYLOAD_LEN = 100,
   parameter int          TCPH_LEN    = 20,
   parameter int          IPH_LEN     = 20,
   parameter logic [47:0] DST_MAC     = 48'h02_00_00_00_00_02,
   parameter logic [47:0] SRC_MAC     = 48'h02_00_00_00_00_01,
   parameter int          IFG_CYCLES  = 12
) (
   input  logic            clk,
   input  logic            rst_n,
   eth_tx_framer_if.slave  bus,
   output logic            busy,
   output logic [15:0]     frame_count
);

   localparam int PKT_LEN  = PAYLOAD_LEN + TCPH_LEN + IPH_LEN;
   localparam int BODY_END = ETH_HDR_LEN + PKT_LEN;
   localparam bit NEED_PAD = BODY_END < MIN_FRAME;
   localparam int PAD_LEN  = NEED_PAD ? MIN_FRAME - BODY_END : 1;

   localparam logic [111:0] HDR = {DST_MAC, SRC_MAC, ETHERTYPE};

   state_t               state_q;
   state_t               state_d;
   logic [10:0]          cnt_q;
   logic [PKT_LEN*8-1:0] buf_q;
   logic [31:0]          crc;
   logic [111:0]         hdr_sh;
   logic [31:0]          fcs_sh;
   logic                 accept;
   logic                 xfer;
   logic                 crc_en;

   assign accept = bus.in_valid && bus.in_ready;
   assign xfer   = bus.out_valid && bus.out_ready;

   eth_crc32 u_crc (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (accept),
      .en    (crc_en && xfer),
      .din   (bus.out_data),
      .crc   (crc)
   );

   // state register plus per-state byte/cycle counter
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         if (state_d != state_q) begin
            cnt_q <= '0;
         end else if (xfer || state_q == ST_GAP) begin
            cnt_q <= cnt_q + 11'd1;
         end
      end
   end

   // next-state: each state ends on its last transferred byte
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (accept) state_d = ST_HDR;
         ST_HDR:
            if (xfer && cnt_q == 11'(ETH_HDR_LEN - 1))
               state_d = ST_BODY;
         ST_BODY:
            if (xfer && cnt_q == 11'(PKT_LEN - 1))
               state_d = NEED_PAD ? ST_PAD : ST_FCS;
         ST_PAD:
            if (xfer && cnt_q == 11'(PAD_LEN - 1))
               state_d = ST_FCS;
         ST_FCS:
            if (xfer && cnt_q == 11'd3)
               state_d = ST_GAP;
         ST_GAP:
            if (cnt_q == 11'(IFG_CYCLES - 1))
               state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // packet buffer: load on accept, shift out one byte per BODY beat
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         buf_q <= '0;
      end else if (accept) begin
         buf_q <= bus.in_data;
      end else if (xfer && state_q == ST_BODY) begin
         buf_q <= {buf_q[PKT_LEN*8-9:0], 8'h00};
      end
   end

   // completed-frame counter, bumped when the final FCS byte leaves
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         frame_count <= '0;
      end else if (xfer && bus.out_last) begin
         frame_count <= frame_count + 16'd1;
      end
   end

   // output decode from state and counter
   always_comb begin
      hdr_sh        = HDR >> {4'd13 - cnt_q[3:0], 3'b000};
      fcs_sh        = (~crc) >> {cnt_q[1:0], 3'b000};
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      bus.out_last  = 1'b0;
      bus.out_data  = 8'h00;
      busy          = 1'b1;
      crc_en        = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            bus.in_ready = 1'b1;
            busy         = 1'b0;
         end
         ST_HDR: begin
            bus.out_valid = 1'b1;
            bus.out_data  = hdr_sh[7:0];
            crc_en        = 1'b1;
         end
         ST_BODY: begin
            bus.out_valid = 1'b1;
            bus.out_data  = buf_q[PKT_LEN*8-1 -: 8];
            crc_en        = 1'b1;
         end
         ST_PAD: begin
            bus.out_valid = 1'b1;
            crc_en        = 1'b1;
         end
         ST_FCS: begin
            bus.out_valid = 1'b1;
            bus.out_data  = fcs_sh[7:0];
            bus.out_last  = cnt_q == 11'd3;
         end
         ST_GAP: begin
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_eth_tx_framer.sv
// Directed bench for eth_tx_framer and its CRC unit.
// Two framers: default 140-byte packet, and padded 42-byte packet.
module tb_eth_tx_framer;

   localparam int LA = 140;
   localparam int LB = 42;
   localparam int FA = 158;
   localparam int FB = 64;

   typedef logic [7:0] bq_t[$];

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   eth_tx_framer_if #(.PKT_LEN(LA)) a_if();
   eth_tx_framer_if #(.PKT_LEN(LB)) b_if();

   logic        a_busy;
   logic        b_busy;
   logic [15:0] a_fc;
   logic [15:0] b_fc;

   logic        c_clr;
   logic        c_en;
   logic [7:0]  c_din;
   logic [31:0] c_crc;

   eth_tx_framer dut_a (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (a_if),
      .busy        (a_busy),
      .frame_count (a_fc)
   );

   eth_tx_framer #(.PAYLOAD_LEN(2)) dut_b (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (b_if),
      .busy        (b_busy),
      .frame_count (b_fc)
   );

   eth_crc32 crc_u (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (c_clr),
      .en    (c_en),
      .din   (c_din),
      .crc   (c_crc)
   );

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0] hdr_exp [14] = '{
      8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02,
      8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01,
      8'h08, 8'h00
   };

   bq_t rx;
   int  n_last;
   int  last_pos;
   int  stall_bad;
   int  low_cyc;
   int  guard;
   int  cnt;
   int  nz;
   logic [31:0] c;
   bq_t pa, pb, p2, p3, ea, eb;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] m_crc(input logic [31:0] ci,
                                         input logic [7:0] d);
      logic [31:0] r;
      logic        fb;
      r = ci;
      for (int i = 0; i < 8; i++) begin
         fb = r[0] ^ d[i];
         r  = {1'b0, r[31:1]};
         if (fb) r = r ^ 32'hEDB88320;
      end
      return r;
   endfunction

   function automatic bq_t mk_pkt(input int n, input int seed);
      bq_t p;
      for (int i = 0; i < n; i++)
         p.push_back(8'((i * seed + 3 * seed + 1) & 255));
      return p;
   endfunction

   function automatic bq_t mk_frame(input bq_t pkt);
      bq_t         f;
      logic [31:0] r;
      logic [31:0] fcs;
      foreach (hdr_exp[i]) f.push_back(hdr_exp[i]);
      foreach (pkt[i]) f.push_back(pkt[i]);
      while (f.size() < 60) f.push_back(8'h00);
      r = 32'hFFFFFFFF;
      foreach (f[i]) r = m_crc(r, f[i]);
      fcs = ~r;
      for (int i = 0; i < 4; i++) f.push_back(fcs[8*i +: 8]);
      return f;
   endfunction

   function automatic logic [LA*8-1:0] pack_a(input bq_t p);
      logic [LA*8-1:0] v;
      v = '0;
      for (int i = 0; i < LA; i++) v[(LA-1-i)*8 +: 8] = p[i];
      return v;
   endfunction

   function automatic logic [LB*8-1:0] pack_b(input bq_t p);
      logic [LB*8-1:0] v;
      v = '0;
      for (int i = 0; i < LB; i++) v[(LB-1-i)*8 +: 8] = p[i];
      return v;
   endfunction

   function automatic int ndiff(input bq_t x, input bq_t y);
      int n;
      int m;
      n = 0;
      m = (x.size() > y.size()) ? x.size() : y.size();
      for (int i = 0; i < m; i++)
         if (i >= x.size() || i >= y.size() || x[i] !== y[i]) n++;
      return n;
   endfunction

   function automatic logic [31:0] residue(input bq_t f);
      logic [31:0] r;
      r = 32'hFFFFFFFF;
      foreach (f[i]) r = m_crc(r, f[i]);
      return r;
   endfunction

   // Called at a negedge; records one frame and the following gap.
   task automatic collect_a(input bit rnd);
      int         g;
      bit         seen;
      bit         pst;
      logic [7:0] pd;
      logic       pv;
      logic       pl;
      g = 0; seen = 0; pst = 0; pd = 0; pv = 0; pl = 0;
      rx.delete();
      n_last = 0; last_pos = 0; stall_bad = 0; low_cyc = 0;
      while (!(seen && a_if.in_ready) && g < 4000) begin
         a_if.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (pst && (a_if.out_data !== pd || a_if.out_valid !== pv ||
                     a_if.out_last !== pl))
            stall_bad++;
         if (a_if.out_valid && a_if.out_ready) begin
            rx.push_back(a_if.out_data);
            if (a_if.out_last) begin
               n_last++;
               last_pos = rx.size();
               seen = 1;
            end
         end
         if (!a_if.in_ready) low_cyc++;
         pst = a_if.out_valid && !a_if.out_ready;
         pd = a_if.out_data; pv = a_if.out_valid; pl = a_if.out_last;
         @(negedge clk);
         g++;
      end
      a_if.out_ready = 1'b1;
      chk("collect_done", 32'(seen), 32'd1);
   endtask

   task automatic send_a(input bq_t p);
      a_if.in_data  = pack_a(p);
      a_if.in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      a_if.in_valid = 1'b0;
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      a_if.in_valid = 1'b0; a_if.in_data = '0; a_if.out_ready = 1'b1;
      b_if.in_valid = 1'b0; b_if.in_data = '0; b_if.out_ready = 1'b1;
      c_clr = 1'b0; c_en = 1'b0; c_din = 8'h00;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);

      chk("rst_out_valid", 32'(a_if.out_valid), 32'd0);
      chk("rst_out_last", 32'(a_if.out_last), 32'd0);
      chk("rst_out_data", 32'(a_if.out_data), 32'd0);
      chk("rst_in_ready", 32'(a_if.in_ready), 32'd1);
      chk("rst_busy", 32'(a_busy), 32'd0);
      chk("rst_fcount", 32'(a_fc), 32'd0);
      chk("rst_crc", c_crc, 32'hFFFFFFFF);
      rst_n = 1'b1;
      @(negedge clk);

      c_clr = 1'b1;
      @(negedge clk);
      c_clr = 1'b0; c_en = 1'b1;
      for (int i = 0; i < 9; i++) begin
         c_din = 8'h31 + 8'(i);
         @(negedge clk);
      end
      c_en = 1'b0;
      chk("crc_check_123456789", ~c_crc, 32'hCBF43926);

      pa = mk_pkt(LA, 3);
      ea = mk_frame(pa);
      send_a(pa);
      chk("t1_first_valid", 32'(a_if.out_valid), 32'd1);
      chk("t1_first_byte", 32'(a_if.out_data), 32'h02);
      chk("t1_in_ready_low", 32'(a_if.in_ready), 32'd0);
      chk("t1_busy", 32'(a_busy), 32'd1);
      collect_a(1'b0);
      chk("t1_len", rx.size(), FA);
      for (int i = 0; i < 14; i++)
         chk($sformatf("t1_hdr%0d", i),
             (i < rx.size()) ? 32'(rx[i]) : 32'hFFFF, 32'(hdr_exp[i]));
      chk("t1_diff", ndiff(rx, ea), 0);
      chk("t1_last_cnt", n_last, 1);
      chk("t1_last_pos", last_pos, FA);
      chk("t1_ready_low_cyc", low_cyc, FA + 12);
      chk("t1_fcount", 32'(a_fc), 32'd1);
      chk("t1_residue", residue(rx), 32'hDEBB20E3);
      chk("t1_gap_valid", 32'(a_if.out_valid), 32'd0);

      pb = mk_pkt(LB, 5);
      eb = mk_frame(pb);
      b_if.in_data  = pack_b(pb);
      b_if.in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      b_if.in_valid = 1'b0;
      rx.delete(); n_last = 0; last_pos = 0; guard = 0;
      while (n_last == 0 && guard < 500) begin
         if (b_if.out_valid && b_if.out_ready) begin
            rx.push_back(b_if.out_data);
            if (b_if.out_last) begin
               n_last++;
               last_pos = rx.size();
            end
         end
         @(negedge clk);
         guard++;
      end
      chk("b_len", rx.size(), FB);
      chk("b_last_pos", last_pos, FB);
      nz = 0;
      for (int i = 56; i < 60; i++)
         if (i >= rx.size() || rx[i] !== 8'h00) nz++;
      chk("b_pad_zero", nz, 0);
      chk("b_diff", ndiff(rx, eb), 0);
      chk("b_residue", residue(rx), 32'hDEBB20E3);
      chk("b_fcount", 32'(b_fc), 32'd1);

      send_a(pa);
      collect_a(1'b1);
      chk("t2_diff", ndiff(rx, ea), 0);
      chk("t2_stall_stable", stall_bad, 0);
      chk("t2_last_cnt", n_last, 1);
      chk("t2_fcount", 32'(a_fc), 32'd2);

      p2 = mk_pkt(LA, 11);
      p3 = mk_pkt(LA, 13);
      a_if.in_data  = pack_a(p2);
      a_if.in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      a_if.in_data = pack_a(p3);
      collect_a(1'b0);
      chk("t3_f1_diff", ndiff(rx, mk_frame(p2)), 0);
      chk("t3_ready_low_cyc", low_cyc, FA + 12);
      chk("t3_idle_ready", 32'(a_if.in_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      a_if.in_valid = 1'b0;
      chk("t3_f2_valid", 32'(a_if.out_valid), 32'd1);
      collect_a(1'b0);
      chk("t3_f2_diff", ndiff(rx, mk_frame(p3)), 0);
      chk("t3_fcount", 32'(a_fc), 32'd4);

      send_a(pa);
      cnt = 0; guard = 0;
      while (cnt < 80 && guard < 500) begin
         if (a_if.out_valid && a_if.out_ready) cnt++;
         @(negedge clk);
         guard++;
      end
      chk("t4_reached80", cnt, 80);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("t4_out_valid", 32'(a_if.out_valid), 32'd0);
      chk("t4_out_last", 32'(a_if.out_last), 32'd0);
      chk("t4_fcount", 32'(a_fc), 32'd0);
      chk("t4_in_ready", 32'(a_if.in_ready), 32'd1);
      nz = 0;
      for (int i = 0; i < 20; i++) begin
         if (a_if.out_valid) nz++;
         @(negedge clk);
      end
      chk("t4_quiet", nz, 0);
      send_a(pa);
      collect_a(1'b0);
      chk("t4_diff", ndiff(rx, ea), 0);
      chk("t4_fcount_after", 32'(a_fc), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/eth_tx_framer.md
ETH_TX_FRAMER -- requirements
Module: eth_tx_framer

Interface
REQ-001 SHALL have parameter PAYLOAD_LEN, default 100, FIX payload bytes per packet.
REQ-002 SHALL have parameter TCPH_LEN, default 20, TCP header bytes.
REQ-003 SHALL have parameter IPH_LEN, default 20, IP header bytes; derived localparam PKT_LEN = PAYLOAD_LEN+TCPH_LEN+IPH_LEN.
REQ-004 SHALL have parameter DST_MAC, default 48'h02_00_00_00_00_02, destination MAC.
REQ-005 SHALL have parameter SRC_MAC, default 48'h02_00_00_00_00_01, source MAC.
REQ-006 SHALL have parameter IFG_CYCLES, default 12, idle cycles after each frame.
REQ-007 clk  input  1  clock; all logic on rising edge.
REQ-008 rst_n  input  1  reset, synchronous, active-low.
REQ-009 in_data  input  PKT_LEN*8  complete IP packet from the network stack; byte 0 = bits [PKT_LEN*8-1 -: 8].
REQ-010 in_valid  input  1  in_data holds a packet.
REQ-011 in_ready  output  1  framer accepts a packet this cycle.
REQ-012 out_data  output  8  frame byte.
REQ-013 out_valid  output  1  out_data valid.
REQ-014 out_last  output  1  marks final FCS byte.
REQ-015 out_ready  input  1  downstream MAC/PHY accepts byte.
REQ-016 busy  output  1  high in any state other than IDLE.
REQ-017 frame_count  output  16  completed frames, wraps 16'hFFFF -> 0.

Function
REQ-018 SHALL accept a packet on in_valid && in_ready, registering in_data into an internal PKT_LEN-byte buffer; in_ready SHALL be 1 only in IDLE.
REQ-019 SHALL present the first header byte with out_valid=1 on the cycle after acceptance.
REQ-020 SHALL transfer a byte only on out_valid && out_ready; while out_ready=0, out_data/out_valid/out_last SHALL hold stable.
REQ-021 States: IDLE, HDR, BODY, PAD, FCS, GAP; IDLE->HDR on accept; HDR->BODY after 14 bytes; BODY->PAD after PKT_LEN bytes if 14+PKT_LEN<60, else BODY->FCS; PAD->FCS when 60 bytes sent; FCS->GAP after 4 bytes; GAP->IDLE after IFG_CYCLES cycles.
REQ-022 HDR byte order: DST_MAC MSB first, SRC_MAC MSB first, then 8'h08, 8'h00.
REQ-023 BODY SHALL emit buffer bytes 0..PKT_LEN-1 in order; PAD SHALL emit 8'h00.
REQ-024 CRC-32 (reflected poly 32'hEDB88320, init 32'hFFFFFFFF) SHALL be updated once per transferred HDR/BODY/PAD byte, and SHALL be re-initialised on accept.
REQ-025 FCS SHALL emit ~crc LSB-byte first ([7:0],[15:8],[23:16],[31:24]); out_last=1 only with byte [31:24].
REQ-026 Byte counter SHALL be 11 bits, reset to 0 on every state entry.
REQ-027 frame_count SHALL increment on the cycle the out_last byte transfers.
REQ-028 in_valid asserted while busy SHALL be ignored; the source holds it until in_ready.
REQ-029 out_valid SHALL be 0 in IDLE and GAP.

Reset
REQ-030 On rst_n=0 at a clock edge: state IDLE, out_valid=0, out_last=0, out_data=0, in_ready=1 from the following cycle, busy=0, frame_count=0, crc=32'hFFFFFFFF, counters 0.
REQ-031 Reset mid-frame SHALL abort the frame with no further bytes and no out_last.

Structure
REQ-032 Shared package: ETH header length 14, ethertype 16'h0800, min frame 60, CRC poly/init/residue constants, state encoding.
REQ-033 One sub-module eth_crc32: byte-wide combinational next-CRC function plus clear/enable register.

Verification
REQ-034 CRC unit: bytes "123456789" (8'h31..8'h39) -> final ~crc = 32'hCBF43926.
REQ-035 Default params, out_ready=1, one packet -> 158 bytes, bytes 0..13 = 02 00 00 00 00 02 02 00 00 00 00 01 08 00, out_last on byte 158 only, frame_count=1, in_ready low for 158+12 cycles after accept.
REQ-036 PAYLOAD_LEN=2 (PKT_LEN=42) -> 14+42 bytes, 4 bytes 8'h00 pad, 4 FCS bytes, 64 total; CRC over received frame incl. FCS yields residue 32'hDEBB20E3.
REQ-037 Random out_ready (50%) -> byte sequence identical to out_ready=1 run; outputs stable during every stall.
REQ-038 in_valid held through frame with new data -> second packet accepted only on first IDLE cycle after GAP; first frame unchanged.
REQ-039 rst_n=0 at byte 80 -> out_valid=0 next cycle, frame_count=0, next packet produces a correct full frame.
